exe_mc_ctrl: RTL and testbench
==============================

Name: exe_mc_ctrl

Overview:
Sequencing controller for multi-cycle operations executed in the Execute stage: integer multiply, integer divide/remainder, and FP divide/sqrt.
- Detects a multi-cycle op entering E and issues a start pulse to the shared iterative unit.
- Counts the op's fixed latency while stalling the front of the pipeline, then presents the result for one advancing cycle.
- Its stall output is ORed with the load-use stall from Exe_stage; kill (exception/interrupt squash) aborts it.

Parameters:
MUL_LAT, 2, cycles from start pulse to result for MUL/MULH*
DIV_LAT, 32, cycles from start pulse to result for DIV/DIVU/REM/REMU
FDIV_LAT, 24, cycles from start pulse to result for FDIV.S/FSQRT.S

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
E_valid  in  1  E stage holds a real instruction (not a bubble)
E_mc_op  in  2  0=none, 1=MUL, 2=DIV, 3=FDIV/FSQRT
kill  in  1  squash instruction in E this cycle
mem_stall  in  1  downstream M stage cannot accept
unit_start  out  1  one-cycle start pulse to iterative unit
unit_sel  out  2  op class latched at start; held stable through RUN/HOLD
unit_kill  out  1  one-cycle abort pulse to iterative unit
mc_stall  out  1  hold F/D/E pipeline registers
mc_result_valid  out  1  iterative unit result selected onto E_alu_out this cycle
mc_busy  out  1  state != IDLE
perf_mc_stall_cnt  out  32  free-running count of cycles with mc_stall=1, wraps at 2^32

Behaviour:
Reset (rst=0 at a clk edge), including mid-operation:
- state=IDLE, counter=0, perf_mc_stall_cnt=0.
- unit_sel=0; all pulse/level outputs 0.
- The iterative unit is not sent unit_kill; it is reset by the same rst.

States are IDLE, RUN, HOLD.

IDLE:
- issue = E_valid & (E_mc_op!=0) & ~kill.
- On issue: unit_start=1, mc_stall=1 (combinational, same cycle), latch unit_sel=E_mc_op, load counter=LAT(op)-1, go to RUN.
- kill with a pending op: no start, no stall, stay IDLE.

RUN:
- mc_stall=1; counter decrements each cycle.
- When counter==1, go to HOLD, so HOLD is entered exactly LAT cycles after the unit_start cycle.
- E_valid and E_mc_op are ignored in RUN, since E is frozen by the stall.

HOLD:
- mc_result_valid=1.
- mc_stall = mem_stall.
- If ~mem_stall, the instruction advances at this edge and the state returns to IDLE; the next E contents are evaluated fresh in IDLE.
- If mem_stall, stay in HOLD with mc_result_valid held.

Latency special case:
- LAT=1 is legal: IDLE goes directly to HOLD (counter load 0, RUN skipped).
- LAT must be >=1; the bench checks this with an assertion.

kill in RUN or HOLD:
- unit_kill=1 for that cycle, mc_stall=0, mc_result_valid=0.
- Next state is IDLE; unit_sel clears to 0.

kill takes priority over mem_stall and over counter expiry in the same cycle.

perf_mc_stall_cnt increments on every cycle in which mc_stall=1, after reset deassertion.

Counter width is clog2(max(MUL_LAT,DIV_LAT,FDIV_LAT)+1).

Back-to-back multi-cycle ops:
- The second op issues in the cycle after HOLD releases.
- There is a minimum one-cycle gap between the first op's unit_start and its own HOLD. There is no idle bubble between the release and the next start.

Decomposition:
Package exe_mc_pkg holds:
- enum mc_op_e {MC_NONE, MC_MUL, MC_DIV, MC_FDIV}
- enum mc_state_e {MC_IDLE, MC_RUN, MC_HOLD}
- default latency localparams

One sub-module is natural: mc_lat_cnt, a loadable down-counter with zero/one flags. The FSM and outputs stay in exe_mc_ctrl.

Test Plan:
- MUL issue at cycle 10 (E_valid=1, E_mc_op=1) -> unit_start@10; mc_stall high on 10–11; mc_result_valid@12; mc_stall low@12; mc_busy low@13.
- DIV issue at cycle 0 -> unit_sel=2 held through 0..32; mc_result_valid only @32; perf_mc_stall_cnt=32 at cycle 33.
- DIV then FDIV back-to-back -> second unit_start in the cycle after DIV HOLD releases; FDIV HOLD 24 cycles after that start; no overlapping start pulses.
- mem_stall=1 held for 3 cycles spanning DIV HOLD -> mc_result_valid and mc_stall held high for those 3 cycles; IDLE on the cycle after mem_stall drops.
- kill at RUN cycle 5 of DIV -> unit_kill pulse that cycle, mc_stall=0, IDLE next. kill in the same cycle as issue -> no unit_start, no stall.
- rst=0 asserted mid-RUN of FDIV -> next cycle state IDLE, all outputs 0, perf_mc_stall_cnt=0, no unit_kill; a new MUL issued after rst=1 completes with normal 2-cycle latency.

Source files
------------

// File: rtl/exe_mc_pkg.sv
// ----------------------------------------------------------------------------
// exe_mc_pkg
// Shared types and defaults for the Execute-stage multi-cycle op controller.
//   mc_op_e    : op class carried on E_mc_op / unit_sel
//   mc_state_e : controller sequencing states
//   MC_*_LAT_DEF : default start-to-result latencies per op class
//   mc_max3    : helper used to size the latency counter
// ----------------------------------------------------------------------------
package exe_mc_pkg;

    typedef enum logic [1:0] {
        MC_NONE = 2'd0,
        MC_MUL  = 2'd1,
        MC_DIV  = 2'd2,
        MC_FDIV = 2'd3
    } mc_op_e;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_RUN  = 2'd1,
        MC_HOLD = 2'd2
    } mc_state_e;

    localparam int unsigned MC_MUL_LAT_DEF  = 2;
    localparam int unsigned MC_DIV_LAT_DEF  = 32;
    localparam int unsigned MC_FDIV_LAT_DEF = 24;

    function automatic int unsigned mc_max3(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/mc_lat_cnt.sv
// ----------------------------------------------------------------------------
// mc_lat_cnt
// Loadable down-counter with zero/one flags, used to time a multi-cycle op.
//   i_clk      : clock
//   i_rst_n    : synchronous active-low reset (count -> 0)
//   i_clr      : clear count to 0 (highest priority after reset)
//   i_load     : load i_load_val
//   i_load_val : value to load
//   i_dec      : decrement by one (saturates at 0)
//   o_cnt      : current count
//   o_zero     : count == 0
//   o_one      : count == 1
// ----------------------------------------------------------------------------
module mc_lat_cnt #(
    parameter int unsigned W = 6
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_zero,
    output logic         o_one
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);
    assign o_one  = (r_cnt == W'(1));

endmodule

// File: rtl/exe_mc_ctrl.sv
// ----------------------------------------------------------------------------
// exe_mc_ctrl
// Sequences multi-cycle Execute ops (MUL, DIV/REM, FDIV/FSQRT) on a shared
// iterative unit: pulses a start, stalls F/D/E for the op's fixed latency,
// then presents the result for one advancing cycle.
//   clk               : clock
//   rst               : synchronous active-low reset
//   E_valid           : E holds a real instruction
//   E_mc_op           : 0 none, 1 MUL, 2 DIV, 3 FDIV/FSQRT
//   kill              : squash the instruction in E this cycle
//   mem_stall         : M stage cannot accept
//   unit_start        : one-cycle start pulse to iterative unit
//   unit_sel          : op class, valid from start through HOLD
//   unit_kill         : one-cycle abort pulse to iterative unit
//   mc_stall          : hold F/D/E pipeline registers
//   mc_result_valid   : iterative result selected onto E_alu_out
//   mc_busy           : controller not idle
//   perf_mc_stall_cnt : free-running count of mc_stall cycles
// ----------------------------------------------------------------------------
module exe_mc_ctrl
    import exe_mc_pkg::*;
#(
    parameter int unsigned MUL_LAT  = MC_MUL_LAT_DEF,
    parameter int unsigned DIV_LAT  = MC_DIV_LAT_DEF,
    parameter int unsigned FDIV_LAT = MC_FDIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        E_valid,
    input  logic [1:0]  E_mc_op,
    input  logic        kill,
    input  logic        mem_stall,
    output logic        unit_start,
    output logic [1:0]  unit_sel,
    output logic        unit_kill,
    output logic        mc_stall,
    output logic        mc_result_valid,
    output logic        mc_busy,
    output logic [31:0] perf_mc_stall_cnt
);

    localparam int unsigned MAX_LAT = mc_max3(MUL_LAT, DIV_LAT, FDIV_LAT);
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0] MUL_M1  = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV_LAT - 1);
    localparam logic [CW-1:0] FDIV_M1 = CW'(FDIV_LAT - 1);

    mc_state_e     r_state;
    mc_state_e     w_state_nxt;
    mc_op_e        r_sel;
    mc_op_e        w_sel;
    mc_op_e        w_op;
    logic [31:0]   r_perf;

    logic          w_issue;
    logic          w_start;
    logic          w_ukill;
    logic          w_stall;
    logic          w_rvalid;
    logic          w_cnt_load;
    logic          w_cnt_dec;
    logic          w_cnt_clr;
    logic [CW-1:0] w_lat_m1;
    logic [CW-1:0] w_cnt;
    logic          w_cnt_zero;
    logic          w_cnt_one;

    assign w_op    = mc_op_e'(E_mc_op);
    assign w_issue = E_valid && (w_op != MC_NONE) && !kill;

    always_comb begin
        w_lat_m1 = '0;
        case (w_op)
            MC_MUL:  w_lat_m1 = MUL_M1;
            MC_DIV:  w_lat_m1 = DIV_M1;
            MC_FDIV: w_lat_m1 = FDIV_M1;
            default: w_lat_m1 = '0;
        endcase
    end

    mc_lat_cnt #(
        .W (CW)
    ) u_lat_cnt (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_clr      (w_cnt_clr),
        .i_load     (w_cnt_load),
        .i_load_val (w_lat_m1),
        .i_dec      (w_cnt_dec),
        .o_cnt      (w_cnt),
        .o_zero     (w_cnt_zero),
        .o_one      (w_cnt_one)
    );

    // Reset is folded into next-state/output decode so that a reset cycle
    // never emits a start, kill or stall, even mid-operation.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_ukill     = 1'b0;
        w_stall     = 1'b0;
        w_rvalid    = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_sel       = MC_NONE;
        if (!rst) begin
            w_state_nxt = MC_IDLE;
            w_cnt_clr   = 1'b1;
        end else begin
            case (r_state)
                MC_IDLE: begin
                    if (w_issue) begin
                        w_start     = 1'b1;
                        w_stall     = 1'b1;
                        w_cnt_load  = 1'b1;
                        w_sel       = w_op;
                        // Latency of 1 skips RUN entirely.
                        w_state_nxt = (w_lat_m1 == '0) ? MC_HOLD : MC_RUN;
                    end
                end
                MC_RUN: begin
                    w_sel = r_sel;
                    if (kill) begin
                        w_ukill     = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = MC_IDLE;
                    end else begin
                        w_stall   = 1'b1;
                        w_cnt_dec = 1'b1;
                        if (w_cnt_one || w_cnt_zero) w_state_nxt = MC_HOLD;
                    end
                end
                MC_HOLD: begin
                    w_sel = r_sel;
                    if (kill) begin
                        w_ukill     = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = MC_IDLE;
                    end else begin
                        w_rvalid = 1'b1;
                        w_stall  = mem_stall;
                        if (!mem_stall) w_state_nxt = MC_IDLE;
                    end
                end
                default: begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = MC_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= MC_IDLE;
            r_sel   <= MC_NONE;
            r_perf  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == MC_IDLE) begin
                r_sel <= MC_NONE;
            end else if (w_start) begin
                r_sel <= w_op;
            end
            if (w_stall) r_perf <= r_perf + 32'd1;
        end
    end

    assign unit_start        = w_start;
    assign unit_sel          = w_sel;
    assign unit_kill         = w_ukill;
    assign mc_stall          = w_stall;
    assign mc_result_valid   = w_rvalid;
    assign mc_busy           = (r_state != MC_IDLE);
    assign perf_mc_stall_cnt = r_perf;

endmodule

// File: tb/tb_exe_mc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_exe_mc_ctrl
// Drives two controller instances (default latencies, and short latencies
// including a latency of 1) with the same stimulus and compares every output
// each cycle against a transaction-level model: an op is either absent or in
// flight with a known class and elapsed-cycle count since its start.
// ----------------------------------------------------------------------------
module tb_exe_mc_ctrl;

    localparam int unsigned A_MUL = 2, A_DIV = 32, A_FDIV = 24;
    localparam int unsigned B_MUL = 1, B_DIV = 3,  B_FDIV = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       E_valid;
    logic [1:0] E_mc_op;
    logic       kill;
    logic       mem_stall;

    logic        o_start [2];
    logic [1:0]  o_sel   [2];
    logic        o_ukill [2];
    logic        o_stall [2];
    logic        o_rv    [2];
    logic        o_busy  [2];
    logic [31:0] o_perf  [2];

    exe_mc_ctrl #(
        .MUL_LAT  (A_MUL),
        .DIV_LAT  (A_DIV),
        .FDIV_LAT (A_FDIV)
    ) u_dut_a (
        .clk               (clk),
        .rst               (rst),
        .E_valid           (E_valid),
        .E_mc_op           (E_mc_op),
        .kill              (kill),
        .mem_stall         (mem_stall),
        .unit_start        (o_start[0]),
        .unit_sel          (o_sel[0]),
        .unit_kill         (o_ukill[0]),
        .mc_stall          (o_stall[0]),
        .mc_result_valid   (o_rv[0]),
        .mc_busy           (o_busy[0]),
        .perf_mc_stall_cnt (o_perf[0])
    );

    exe_mc_ctrl #(
        .MUL_LAT  (B_MUL),
        .DIV_LAT  (B_DIV),
        .FDIV_LAT (B_FDIV)
    ) u_dut_b (
        .clk               (clk),
        .rst               (rst),
        .E_valid           (E_valid),
        .E_mc_op           (E_mc_op),
        .kill              (kill),
        .mem_stall         (mem_stall),
        .unit_start        (o_start[1]),
        .unit_sel          (o_sel[1]),
        .unit_kill         (o_ukill[1]),
        .mc_stall          (o_stall[1]),
        .mc_result_valid   (o_rv[1]),
        .mc_busy           (o_busy[1]),
        .perf_mc_stall_cnt (o_perf[1])
    );

    // Reference model state per instance.
    int unsigned lat   [2][4];
    bit          m_act [2];
    int unsigned m_op  [2];
    int unsigned m_el  [2];
    logic [31:0] m_perf[2];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] op,
                        input logic k, input logic ms);
        bit          e_start, e_ukill, e_rv, e_stall;
        int unsigned e_sel;
        @(negedge clk);
        rst = r; E_valid = v; E_mc_op = op; kill = k; mem_stall = ms;
        #1;
        for (int i = 0; i < 2; i++) begin
            e_start = 0; e_ukill = 0; e_rv = 0; e_stall = 0; e_sel = 0;
            if (r) begin
                if (!m_act[i]) begin
                    e_start = v && (op != 2'd0) && !k;
                    e_stall = e_start;
                    e_sel   = e_start ? int'(op) : 0;
                end else begin
                    e_sel   = m_op[i];
                    e_ukill = k;
                    e_rv    = !k && (m_el[i] >= lat[i][m_op[i]]);
                    e_stall = !k && ((m_el[i] < lat[i][m_op[i]]) || ms);
                end
            end
            check_eq($sformatf("u%0d.unit_start", i), 32'(o_start[i]), 32'(e_start));
            check_eq($sformatf("u%0d.unit_sel", i),   32'(o_sel[i]),   32'(e_sel));
            check_eq($sformatf("u%0d.unit_kill", i),  32'(o_ukill[i]), 32'(e_ukill));
            check_eq($sformatf("u%0d.mc_stall", i),   32'(o_stall[i]), 32'(e_stall));
            check_eq($sformatf("u%0d.result_valid", i), 32'(o_rv[i]),  32'(e_rv));
            check_eq($sformatf("u%0d.mc_busy", i),    32'(o_busy[i]),  32'(m_act[i]));
            check_eq($sformatf("u%0d.perf_cnt", i),   o_perf[i],       m_perf[i]);
            // Advance the model to the state after the coming clock edge.
            if (!r) begin
                m_act[i] = 0; m_el[i] = 0; m_op[i] = 0; m_perf[i] = '0;
            end else begin
                if (e_stall) m_perf[i] = m_perf[i] + 32'd1;
                if (m_act[i]) begin
                    if (k || (e_rv && !ms)) m_act[i] = 0;
                    else                    m_el[i]  = m_el[i] + 1;
                end else if (e_start) begin
                    m_act[i] = 1; m_op[i] = int'(op); m_el[i] = 1;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned j = 0; j < n; j++) step(1, 0, 2'd0, 0, 0);
    endtask

    initial begin
        lat[0] = '{0, A_MUL, A_DIV, A_FDIV};
        lat[1] = '{0, B_MUL, B_DIV, B_FDIV};
        assert (A_MUL >= 1 && A_DIV >= 1 && A_FDIV >= 1 &&
                B_MUL >= 1 && B_DIV >= 1 && B_FDIV >= 1)
            else $error("latency parameter below 1");
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_op[i] = 0; m_el[i] = 0; m_perf[i] = '0;
        end
        rst = 0; E_valid = 0; E_mc_op = 0; kill = 0; mem_stall = 0;

        for (int j = 0; j < 3; j++) step(0, 0, 2'd0, 0, 0);
        idle(3);

        // MUL issue, then bubbles.
        step(1, 1, 2'd1, 0, 0);
        idle(4);

        // DIV with mem_stall spanning its HOLD.
        step(1, 1, 2'd2, 0, 0);
        idle(31);
        for (int j = 0; j < 3; j++) step(1, 0, 2'd0, 0, 1);
        idle(3);

        // DIV then FDIV back-to-back: E frozen on DIV, FDIV arrives at release.
        for (int j = 0; j < 33; j++) step(1, 1, 2'd2, 0, 0);
        step(1, 1, 2'd3, 0, 0);
        idle(27);

        // kill in RUN cycle 5 of DIV; kill coincident with issue.
        step(1, 1, 2'd2, 0, 0);
        idle(4);
        step(1, 0, 2'd0, 1, 0);
        idle(2);
        step(1, 1, 2'd1, 1, 0);
        idle(2);

        // kill during HOLD under mem_stall.
        step(1, 1, 2'd1, 0, 0);
        step(1, 0, 2'd0, 0, 1);
        step(1, 0, 2'd0, 0, 1);
        step(1, 0, 2'd0, 1, 1);
        idle(2);

        // Reset mid-FDIV, then a fresh MUL.
        step(1, 1, 2'd3, 0, 0);
        idle(10);
        step(0, 1, 2'd3, 1, 0);
        step(1, 1, 2'd1, 0, 0);
        idle(4);

        // Randomized traffic.
        for (int j = 0; j < 4000; j++) begin
            step(($urandom_range(0, 299) != 0),
                 1'($urandom),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
